status_flags_unit: RTL and testbench
====================================

# status_flags_unit

Holds the architectural Z/C/N/V flags that feed the condition-check stage, applying flag updates from the ALU, from an explicit flag-write instruction, and from an interrupt save/restore shadow register. It sits directly upstream of the condition check: its `status_register` output is that stage's `status_register` input, bit order {Z,C,N,V}. Updates use a valid/ready handshake with the execute stage. A hazard indication tells issue logic when freshly written flags are not yet visible.

## Interface
- No parameters; width fixed at 4 flags.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  execute stage offers an ALU flag update.
- `in_ready`  out  1  update can be accepted this cycle.
- `s_bit`  in  1  instruction requests flag setting.
- `cond_pass`  in  1  instruction's condition passed; `condition_state` from the condition check.
- `alu_flags`  in  4  {Z,C,N,V} produced by the ALU.
- `flag_mask`  in  4  per-flag write enable for ALU updates; 1 means write that flag.
- `msr_we`  in  1  explicit write of all four flags.
- `msr_data`  in  4  value for the explicit write.
- `irq_save`  in  1  copy the live flags into the shadow register.
- `irq_restore`  in  1  copy the shadow register into the live flags.
- `status_register`  out  4  flags presented to the condition check, {Z,C,N,V}.
- `shadow_flags`  out  4  shadow register contents.
- `flag_hazard`  out  1  the flags seen by the condition check are stale.
- `shadow_err`  out  1  sticky error; set by a restore while the shadow is empty.

## Operation
- State: `flags_q[3:0]`, `shadow_q[3:0]`, `shadow_valid`, `shadow_err`, `hazard_q`.
- Reset: `flags_q=0`, `shadow_q=0`, `shadow_valid=0`, `shadow_err=0`, `hazard_q=0`. All outputs are 0 after reset, except `in_ready`, which is 1.
- `in_ready = ~irq_restore & ~msr_we`.
- ALU update fires when `in_valid & in_ready & s_bit & cond_pass`.
  - Then `flags_next[i] = flag_mask[i] ? alu_flags[i] : flags_q[i]`.
  - A handshake without `s_bit`, or without `cond_pass`, completes with no flag change.
- Write priority, highest first:
  1. `rst`
  2. `irq_restore`
  3. `msr_we`
  4. ALU update
- `irq_restore`:
  - Shadow valid: `flags_next = shadow_q` and `shadow_valid` clears.
  - Shadow empty: flags are unchanged and `shadow_err` sets. `shadow_err` clears only on `rst`.
- `irq_save`:
  - `shadow_q <= flags_q`, i.e. the pre-update value, even when a flag write occurs in the same cycle.
  - `shadow_valid` sets.
  - Shadow depth is 1: a save while the shadow is valid overwrites it without error.
- `irq_save` and `irq_restore` in the same cycle:
  - The restore uses the old `shadow_q`.
  - The save then writes the old `flags_q`.
  - `shadow_valid` ends at 1.
- `hazard_q <= 1` on any cycle in which `flags_q` is written, whether or not the value changes; otherwise it is 0.

## Timing
- Every flag write commits at the next rising edge of `clk`: one-cycle latency to `flags_q`.
- Bypass disabled:
  - `status_register = flags_q`.
  - `flag_hazard = hazard_q`, high for exactly the one cycle after each write.
  - Issue must stall flag-dependent instructions while `flag_hazard` is high.
- Bypass enabled:
  - `status_register = flags_next`, combinational from the current-cycle inputs.
  - `flag_hazard` is tied to 0.
- `shadow_flags` and `shadow_err` are registered; they update one cycle after the triggering input.
- `in_ready` is combinational and has no registered dependency.
- `rst` mid-operation: all state clears at that edge and any pending handshake is discarded.

## Configuration
- Macro: `STATUS_FLAGS_BYPASS_EN`.
- Defined:
  - `status_register` forwards `flags_next` in the same cycle.
  - `flag_hazard` is constant 0.
  - Back-to-back flag-dependent instructions need no stall.
- Undefined:
  - `status_register` is the registered `flags_q`.
  - `flag_hazard` is asserted for one cycle after every flag write.

## Test plan
- Reset, then ALU update with `alu_flags=4'b1010`, `flag_mask=4'b1111`, `s_bit=1`, `cond_pass=1`:
  - `status_register` = `4'b1010` one cycle later.
  - Bypass disabled: `flag_hazard` pulses for 1 cycle.
  - Bypass enabled: `status_register` = `4'b1010` in the same cycle.
- Flags `4'b1111`, ALU update `alu_flags=0`, `flag_mask=4'b0101` -> flags become `4'b1010`.
- Same update with `cond_pass=0`, then again with `s_bit=0` -> flags unchanged and `flag_hazard` stays 0.
- `msr_we=1`, `msr_data=4'b0110` together with `in_valid=1` -> `in_ready=0`, flags become `4'b0110`, and the ALU update is held until the next cycle.
- Flags `4'b1001`; `irq_save` together with an ALU write of `4'b0000` -> shadow holds `4'b1001` and flags are `4'b0000`. A later `irq_restore` -> flags return to `4'b1001` and the shadow empties. A second `irq_restore` -> flags unchanged and `shadow_err`=1 until `rst`.
- Assert `rst` in the same cycle as `msr_we` with `msr_data=4'b1111` -> all outputs 0 after the edge and `in_ready`=1.

Source files
------------

// File: rtl/status_flags_unit.sv
// Architectural Z/C/N/V flag register with ALU, explicit-write and interrupt shadow update paths.
// Optional macro STATUS_FLAGS_BYPASS_EN forwards next-state flags combinationally and ties flag_hazard low.
module status_flags_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       s_bit,
   input  logic       cond_pass,
   input  logic [3:0] alu_flags,
   input  logic [3:0] flag_mask,
   input  logic       msr_we,
   input  logic [3:0] msr_data,
   input  logic       irq_save,
   input  logic       irq_restore,
   output logic [3:0] status_register,
   output logic [3:0] shadow_flags,
   output logic       flag_hazard,
   output logic       shadow_err
);

   logic [3:0] flags_q;
   logic [3:0] flags_d;
   logic [3:0] shadow_q;
   logic [3:0] shadow_d;
   logic       shadow_valid_q;
   logic       shadow_valid_d;
   logic       shadow_err_q;
   logic       shadow_err_d;
   logic       flags_we;
   logic       alu_fire;

   assign in_ready = ~irq_restore & ~msr_we;
   assign alu_fire = in_valid & in_ready & s_bit & cond_pass;

   // Next-state selection; restore beats explicit write beats ALU, and save always captures the old flags.
   always_comb begin
      flags_d        = flags_q;
      shadow_d       = shadow_q;
      shadow_valid_d = shadow_valid_q;
      shadow_err_d   = shadow_err_q;
      flags_we       = 1'b0;
      if (irq_restore) begin
         if (shadow_valid_q) begin
            flags_d        = shadow_q;
            flags_we       = 1'b1;
            shadow_valid_d = 1'b0;
         end else begin
            shadow_err_d = 1'b1;
         end
      end else if (msr_we) begin
         flags_d  = msr_data;
         flags_we = 1'b1;
      end else if (alu_fire) begin
         flags_d  = (flags_q & ~flag_mask) | (alu_flags & flag_mask);
         flags_we = 1'b1;
      end else begin
         flags_we = 1'b0;
      end
      if (irq_save) begin
         shadow_d       = flags_q;
         shadow_valid_d = 1'b1;
      end else begin
         shadow_d = shadow_d;
      end
   end

   // Flag and shadow state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q        <= 4'b0000;
         shadow_q       <= 4'b0000;
         shadow_valid_q <= 1'b0;
         shadow_err_q   <= 1'b0;
      end else begin
         flags_q        <= flags_d;
         shadow_q       <= shadow_d;
         shadow_valid_q <= shadow_valid_d;
         shadow_err_q   <= shadow_err_d;
      end
   end

   assign shadow_flags = shadow_q;
   assign shadow_err   = shadow_err_q;

`ifdef STATUS_FLAGS_BYPASS_EN
   assign status_register = flags_d;
   assign flag_hazard     = 1'b0;
`else
   logic hazard_q;

   // Hazard marks the one cycle after any flag write, even if the value did not change.
   always_ff @(posedge clk) begin
      if (rst) begin
         hazard_q <= 1'b0;
      end else begin
         hazard_q <= flags_we;
      end
   end

   assign status_register = flags_q;
   assign flag_hazard     = hazard_q;
`endif

endmodule

// File: tb/tb_status_flags_unit.sv
// Self-checking bench for status_flags_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_status_flags_unit;
   logic       clk = 1'b0;
   logic       rst, in_valid, s_bit, cond_pass, msr_we, irq_save, irq_restore;
   logic [3:0] alu_flags, flag_mask, msr_data;
   logic       in_ready, flag_hazard, shadow_err;
   logic [3:0] status_register, shadow_flags;

   int checks = 0;
   int errors = 0;

   // Architectural model state and its one-step prediction.
   logic [3:0] m_flags, m_shadow;
   logic       m_sv, m_err, m_haz;
   logic [3:0] p_flags, p_shadow;
   logic       p_sv, p_err, p_haz, p_ready;

`ifdef STATUS_FLAGS_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   status_flags_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .s_bit(s_bit), .cond_pass(cond_pass), .alu_flags(alu_flags),
      .flag_mask(flag_mask), .msr_we(msr_we), .msr_data(msr_data),
      .irq_save(irq_save), .irq_restore(irq_restore),
      .status_register(status_register), .shadow_flags(shadow_flags),
      .flag_hazard(flag_hazard), .shadow_err(shadow_err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      rst = 1'b0; in_valid = 1'b0; s_bit = 1'b0; cond_pass = 1'b0;
      alu_flags = 4'b0000; flag_mask = 4'b0000; msr_we = 1'b0; msr_data = 4'b0000;
      irq_save = 1'b0; irq_restore = 1'b0;
   endtask

   task automatic predict();
      logic accepted;
      p_ready  = !(irq_restore || msr_we);
      accepted = in_valid && p_ready;
      p_flags  = m_flags; p_shadow = m_shadow; p_sv = m_sv; p_err = m_err; p_haz = 1'b0;
      if (irq_restore) begin
         if (m_sv) begin p_flags = m_shadow; p_haz = 1'b1; p_sv = 1'b0; end
         else p_err = 1'b1;
      end else if (msr_we) begin
         p_flags = msr_data; p_haz = 1'b1;
      end else if (accepted && s_bit && cond_pass) begin
         for (int i = 0; i < 4; i++) if (flag_mask[i]) p_flags[i] = alu_flags[i];
         p_haz = 1'b1;
      end
      if (irq_save) begin p_shadow = m_flags; p_sv = 1'b1; end
   endtask

   task automatic tick();
      predict();
      @(posedge clk);
      if (rst) begin
         m_flags = 4'b0000; m_shadow = 4'b0000; m_sv = 1'b0; m_err = 1'b0; m_haz = 1'b0;
      end else begin
         m_flags = p_flags; m_shadow = p_shadow; m_sv = p_sv; m_err = p_err; m_haz = p_haz;
      end
      #1;
   endtask

   task automatic test_reset();
      idle(); rst = 1'b1; tick(); idle(); #1;
      checks++; if (status_register !== 4'b0000) begin errors++; $display("FAIL reset_status got %b want 0000", status_register); end
      checks++; if (shadow_flags !== 4'b0000) begin errors++; $display("FAIL reset_shadow got %b want 0000", shadow_flags); end
      checks++; if (flag_hazard !== 1'b0 || shadow_err !== 1'b0) begin errors++; $display("FAIL reset_hz_err got %b%b want 00", flag_hazard, shadow_err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
   endtask

   task automatic test_alu_basic();
      idle(); in_valid = 1'b1; s_bit = 1'b1; cond_pass = 1'b1; alu_flags = 4'b1010; flag_mask = 4'b1111; #1;
      checks++; if (status_register !== (BYPASS ? 4'b1010 : 4'b0000)) begin errors++; $display("FAIL alu_same_cycle got %b want %b", status_register, BYPASS ? 4'b1010 : 4'b0000); end
      tick(); idle(); #1;
      checks++; if (status_register !== 4'b1010) begin errors++; $display("FAIL alu_basic got %b want 1010", status_register); end
      checks++; if (flag_hazard !== !BYPASS) begin errors++; $display("FAIL alu_hazard_pulse got %b want %b", flag_hazard, !BYPASS); end
      tick();
      checks++; if (flag_hazard !== 1'b0) begin errors++; $display("FAIL alu_hazard_drop got %b want 0", flag_hazard); end
   endtask

   task automatic test_mask();
      idle(); msr_we = 1'b1; msr_data = 4'b1111; tick();
      idle(); in_valid = 1'b1; s_bit = 1'b1; cond_pass = 1'b1; alu_flags = 4'b0000; flag_mask = 4'b0101; tick(); idle(); #1;
      checks++; if (status_register !== 4'b1010) begin errors++; $display("FAIL mask_update got %b want 1010", status_register); end
      tick();
   endtask

   task automatic test_no_update();
      idle(); in_valid = 1'b1; s_bit = 1'b1; cond_pass = 1'b0; alu_flags = 4'b0000; flag_mask = 4'b0101; #1;
      checks++; if (status_register !== 4'b1010) begin errors++; $display("FAIL nocond_same got %b want 1010", status_register); end
      tick(); #1;
      checks++; if (status_register !== 4'b1010 || flag_hazard !== 1'b0) begin errors++; $display("FAIL nocond got %b/%b want 1010/0", status_register, flag_hazard); end
      s_bit = 1'b0; cond_pass = 1'b1; tick(); #1;
      checks++; if (status_register !== 4'b1010 || flag_hazard !== 1'b0) begin errors++; $display("FAIL nosbit got %b/%b want 1010/0", status_register, flag_hazard); end
      idle();
   endtask

   task automatic test_msr_priority();
      idle(); in_valid = 1'b1; s_bit = 1'b1; cond_pass = 1'b1; alu_flags = 4'b1001; flag_mask = 4'b1111;
      msr_we = 1'b1; msr_data = 4'b0110; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL msr_ready got %b want 0", in_ready); end
      tick(); msr_we = 1'b0; #1;
      checks++; if (status_register !== (BYPASS ? 4'b1001 : 4'b0110)) begin errors++; $display("FAIL msr_write got %b want %b", status_register, BYPASS ? 4'b1001 : 4'b0110); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL msr_held_ready got %b want 1", in_ready); end
      tick(); idle(); #1;
      checks++; if (status_register !== 4'b1001) begin errors++; $display("FAIL msr_held_alu got %b want 1001", status_register); end
      tick();
   endtask

   task automatic test_shadow();
      idle(); irq_save = 1'b1; in_valid = 1'b1; s_bit = 1'b1; cond_pass = 1'b1; alu_flags = 4'b0000; flag_mask = 4'b1111;
      tick(); idle(); #1;
      checks++; if (shadow_flags !== 4'b1001 || status_register !== 4'b0000) begin errors++; $display("FAIL save_pre got %b/%b want 1001/0000", shadow_flags, status_register); end
      irq_restore = 1'b1; tick(); idle(); #1;
      checks++; if (status_register !== 4'b1001 || shadow_err !== 1'b0) begin errors++; $display("FAIL restore got %b/%b want 1001/0", status_register, shadow_err); end
      irq_restore = 1'b1; tick(); idle(); #1;
      checks++; if (status_register !== 4'b1001 || shadow_err !== 1'b1 || flag_hazard !== 1'b0) begin errors++; $display("FAIL restore_empty got %b/%b/%b want 1001/1/0", status_register, shadow_err, flag_hazard); end
      tick(); tick(); #1;
      checks++; if (shadow_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", shadow_err); end
   endtask

   task automatic test_reset_mid();
      idle(); rst = 1'b1; msr_we = 1'b1; msr_data = 4'b1111; tick(); idle(); #1;
      checks++; if (status_register !== 4'b0000 || shadow_flags !== 4'b0000 || shadow_err !== 1'b0 || flag_hazard !== 1'b0) begin
         errors++; $display("FAIL reset_mid got %b/%b/%b/%b want 0000/0000/0/0", status_register, shadow_flags, shadow_err, flag_hazard); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %b want 1", in_ready); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 49) == 0); in_valid = $urandom_range(0, 1); s_bit = ($urandom_range(0, 3) != 0);
         cond_pass = ($urandom_range(0, 3) != 0); alu_flags = 4'($urandom); flag_mask = 4'($urandom);
         msr_we = ($urandom_range(0, 5) == 0); msr_data = 4'($urandom);
         irq_save = ($urandom_range(0, 5) == 0); irq_restore = ($urandom_range(0, 6) == 0);
         #1; predict();
         checks++; if (in_ready !== p_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", n, in_ready, p_ready); end
         checks++; if (status_register !== (BYPASS ? p_flags : m_flags)) begin errors++; $display("FAIL rnd_status_pre cyc %0d got %b want %b", n, status_register, BYPASS ? p_flags : m_flags); end
         tick();
         checks++; if (shadow_flags !== m_shadow || shadow_err !== m_err) begin errors++; $display("FAIL rnd_shadow cyc %0d got %b/%b want %b/%b", n, shadow_flags, shadow_err, m_shadow, m_err); end
         checks++; if (flag_hazard !== (BYPASS ? 1'b0 : m_haz)) begin errors++; $display("FAIL rnd_hazard cyc %0d got %b want %b", n, flag_hazard, BYPASS ? 1'b0 : m_haz); end
         if (!BYPASS) begin
            checks++; if (status_register !== m_flags) begin errors++; $display("FAIL rnd_status cyc %0d got %b want %b", n, status_register, m_flags); end
         end
      end
      idle();
   endtask

   initial begin
      m_flags = 4'b0000; m_shadow = 4'b0000; m_sv = 1'b0; m_err = 1'b0; m_haz = 1'b0;
      idle();
      test_reset();
      test_alu_basic();
      test_mask();
      test_no_update();
      test_msr_priority();
      test_shadow();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
